// File: rtl/axi2ram_burst_agen.sv
// rtl/axi2ram_burst_agen.sv - expands latched AXI bursts into per-beat RAM commands
// Optional macro AXI2RAM_AGEN_ERR_EN adds the agen_err pulse for unsupported burst shapes.
module axi2ram_burst_agen #(
  parameter int C_AW     = 32,
  parameter int C_ID     = 16,
  parameter int C_RAM_AW = 15,
  parameter int C_RDW    = 128,
  localparam int RAM_BW  = $clog2(C_RDW / 8),
  localparam int AXW     = C_ID + C_AW + 8 + 3 + 2,
  localparam int CMW     = 1 + C_ID + C_RAM_AW + RAM_BW + 3
) (
  input  logic           aclk_s,
  input  logic           rst_n,
  input  logic [AXW-1:0] axch_info,
  input  logic           axch_empty,
  output logic           axch_pop,
  input  logic           ram_cmd_full,
  output logic           ram_cmd_push,
  output logic [CMW-1:0] ram_cmd_info
`ifdef AXI2RAM_AGEN_ERR_EN
  ,
  output logic           agen_err
`endif
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q;
  logic [C_ID-1:0]   id_q;
  logic [C_AW-1:0]   cur_addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;

  logic [C_ID-1:0]   in_id;
  logic [C_AW-1:0]   in_addr;
  logic [7:0]        in_len;
  logic [2:0]        in_size;
  logic [1:0]        in_burst;

  logic [2:0]        eff_size;
  logic [C_AW-1:0]   step;
  logic [C_AW-1:0]   aligned;
  logic [C_AW-1:0]   incr_addr;
  logic [C_AW-1:0]   wrap_mask;
  logic [C_AW-1:0]   addr_d;
  logic              wrap_en;
  logic              last;
  logic              push;
  logic              load;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  assign {in_id, in_addr, in_len, in_size, in_burst} = axch_info;

  // Address stepping is decoded purely from the latched burst descriptor.
  always_comb begin
    eff_size  = (size_q > 3'(RAM_BW)) ? 3'(RAM_BW) : size_q;
    step      = C_AW'(1) << eff_size;
    aligned   = cur_addr_q & ~(step - C_AW'(1));
    incr_addr = aligned + step;
    wrap_en   = (burst_q == 2'b10) && wrap_len_ok(len_q);
    wrap_mask = ((C_AW'(len_q) + C_AW'(1)) << eff_size) - C_AW'(1);
    addr_d    = incr_addr;
    if (burst_q == 2'b00) begin
      addr_d = cur_addr_q;
    end else if (wrap_en) begin
      addr_d = (cur_addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

  assign last = (cnt_q == len_q);
  assign push = (state_q == BURST) && !ram_cmd_full;
  // Pop either from IDLE or on the final beat push so bursts chain with no bubble.
  assign load = rst_n && !axch_empty && ((state_q == IDLE) || (push && last));

  assign axch_pop     = load;
  assign ram_cmd_push = push;
  assign ram_cmd_info = (state_q == BURST) ?
      {last, id_q, cur_addr_q[RAM_BW +: C_RAM_AW], cur_addr_q[RAM_BW-1:0], size_q} : '0;

  always_ff @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      cur_addr_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
    end else if (load) begin
      state_q    <= BURST;
      id_q       <= in_id;
      cur_addr_q <= in_addr;
      len_q      <= in_len;
      size_q     <= in_size;
      burst_q    <= in_burst;
      cnt_q      <= '0;
    end else if (push) begin
      if (last) begin
        state_q <= IDLE;
      end else begin
        cur_addr_q <= addr_d;
        cnt_q      <= cnt_q + 8'd1;
      end
    end
  end

`ifdef AXI2RAM_AGEN_ERR_EN
  assign agen_err = load && ((in_burst == 2'b11) ||
                             ((in_burst == 2'b10) && !wrap_len_ok(in_len)) ||
                             (in_size > 3'(RAM_BW)));
`endif

endmodule
